// File: rtl/param_seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package param_seq_alu_pkg;

    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_NOT_A = 5'd3;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_SUB   = 5'd5;
    localparam logic [4:0] OP_INC_A = 5'd6;
    localparam logic [4:0] OP_DEC_A = 5'd7;
    localparam logic [4:0] OP_SHL_A = 5'd8;
    localparam logic [4:0] OP_SHR_A = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SHL_A) || (op == OP_SHR_A);
    endfunction

endpackage

// File: rtl/param_seq_alu_if.sv
// Request/response handshake bundle between decode, the ALU and writeback.
interface param_seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zf;
    logic             cf;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, c, zf, cf
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, c, zf, cf
    );
endinterface

// File: rtl/param_seq_alu_logic_unit.sv
// Combinational single-cycle ALU ops; result packed as {cf, c}.
module alu_logic_unit
    import param_seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   res
);
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};

    // The extra top bit of the widened add/sub is exactly carry or borrow.
    always_comb begin
        res = a_x;
        case (opcode)
            OP_AND:   res = {1'b0, a & b};
            OP_OR:    res = {1'b0, a | b};
            OP_XOR:   res = {1'b0, a ^ b};
            OP_NOT_A: res = {1'b0, ~a};
            OP_ADD:   res = a_x + b_x;
            OP_SUB:   res = a_x - b_x;
            OP_INC_A: res = a_x + (WIDTH+1)'(1);
            OP_DEC_A: res = a_x - (WIDTH+1)'(1);
            default:  res = a_x;
        endcase
    end
endmodule

// File: rtl/param_seq_alu.sv
// Sequential ALU: FSM, multi-cycle shifter and step counter. Optional
// shift-add multiplier enabled by defining ALU_MUL_EN.
module param_seq_alu
    import param_seq_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    param_seq_alu_if.slave  bus,
    output logic            busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [4:0]         op_r;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   c_r;
    logic               zf_r;
    logic               cf_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     lu_res;
    logic [WIDTH-1:0]   lu_c;
    logic               lu_cf;
    logic [SHAMT_W-1:0] shamt;
    logic               in_ready;
    logic               accept;
    logic               shift_start;
    logic [WIDTH-1:0]   step_acc;
    logic               step_cf;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
`endif

    alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
        .opcode (bus.opcode),
        .a      (bus.a),
        .b      (bus.b),
        .res    (lu_res)
    );

    assign {lu_cf, lu_c} = lu_res;
    assign shamt         = bus.b[SHAMT_W-1:0];
    assign in_ready      = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign shift_start   = is_shift(bus.opcode) && (shamt != '0);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.c         = c_r;
    assign bus.zf        = zf_r;
    assign bus.cf        = cf_r;
    assign busy          = (state != S_IDLE);

    // One EXEC step: a single-bit shift, or one add-and-shift of the multiplier.
    always_comb begin
        step_acc = acc;
        step_cf  = 1'b0;
`ifdef ALU_MUL_EN
        mul_sum    = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
`endif
        if (op_r == OP_SHL_A) begin
            step_acc = {acc[WIDTH-2:0], 1'b0};
            step_cf  = acc[WIDTH-1];
        end else if (op_r == OP_SHR_A) begin
            step_acc = {1'b0, acc[WIDTH-1:1]};
            step_cf  = acc[0];
        end
`ifdef ALU_MUL_EN
        else if (op_r == OP_MUL) begin
            step_acc = {mul_sum[0], acc[WIDTH-1:1]};
            step_cf  = |mul_hi_nxt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            c_r         <= '0;
            zf_r        <= 1'b0;
            cf_r        <= 1'b0;
            out_valid_r <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                S_EXEC: begin
                    acc <= step_acc;
`ifdef ALU_MUL_EN
                    hi  <= mul_hi_nxt;
`endif
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        c_r         <= step_acc;
                        cf_r        <= step_cf;
                        zf_r        <= (step_acc == '0);
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        op_r <= bus.opcode;
                        acc  <= bus.a;
                        if (shift_start) begin
                            cnt         <= CNT_W'(shamt);
                            out_valid_r <= 1'b0;
                            state       <= S_EXEC;
                        end
`ifdef ALU_MUL_EN
                        else if (bus.opcode == OP_MUL) begin
                            acc         <= bus.b;
                            mcand       <= bus.a;
                            hi          <= '0;
                            cnt         <= CNT_W'(WIDTH);
                            out_valid_r <= 1'b0;
                            state       <= S_EXEC;
                        end
`endif
                        else begin
                            c_r         <= lu_c;
                            cf_r        <= lu_cf;
                            zf_r        <= (lu_c == '0);
                            out_valid_r <= 1'b1;
                            state       <= S_DONE;
                        end
                    end else if ((state == S_DONE) && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_seq_alu.sv
// Directed bench for param_seq_alu at WIDTH = 8; honours ALU_MUL_EN.
module tb_param_seq_alu;
    import param_seq_alu_pkg::*;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       cf;
        logic       zf;
        logic [7:0] lat;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_cmp;
    int   n_bad;

    param_seq_alu_if #(.WIDTH(8)) bus ();

    param_seq_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from IDLE, wait for the result, capture it, then retire it.
    task automatic do_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] rc, output logic rcf, output logic rzf,
                         output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        bus.opcode = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rc = bus.c; rcf = bus.cf; rzf = bus.zf;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.c, bus.zf, bus.cf, busy, bus.in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset: got ov=%b c=%h zf=%b cf=%b busy=%b rdy=%b, want 0 00 0 0 0 1",
                     bus.out_valid, bus.c, bus.zf, bus.cf, busy, bus.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith_logic();
        vec_t v [8];
        logic [7:0] rc; logic rcf, rzf; int lat;
        v[0] = '{OP_ADD,   8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 8'd1};
        v[1] = '{OP_SUB,   8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 8'd1};
        v[2] = '{OP_SUB,   8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 8'd1};
        v[3] = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 8'd1};
        v[4] = '{OP_OR,    8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 8'd1};
        v[5] = '{OP_XOR,   8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 8'd1};
        v[6] = '{OP_NOT_A, 8'h0F, 8'hAA, 8'hF0, 1'b0, 1'b0, 8'd1};
        v[7] = '{5'h1F,    8'h3C, 8'h99, 8'h3C, 1'b0, 1'b0, 8'd1};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, rc, rcf, rzf, lat);
            n_cmp++;
            if ({rc, rcf, rzf} !== {v[i].c, v[i].cf, v[i].zf} || lat != int'(v[i].lat)) begin
                n_bad++;
                $display("FAIL arith[%0d] op=%0d: got c=%h cf=%b zf=%b lat=%0d, want c=%h cf=%b zf=%b lat=%0d",
                         i, v[i].op, rc, rcf, rzf, lat, v[i].c, v[i].cf, v[i].zf, v[i].lat);
            end
        end
    endtask

    task automatic test_inc_dec();
        vec_t v [4];
        logic [7:0] rc; logic rcf, rzf; int lat;
        v[0] = '{OP_DEC_A, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 8'd1};
        v[1] = '{OP_INC_A, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 8'd1};
        v[2] = '{OP_INC_A, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 8'd1};
        v[3] = '{OP_DEC_A, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'd1};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, rc, rcf, rzf, lat);
            n_cmp++;
            if ({rc, rcf, rzf} !== {v[i].c, v[i].cf, v[i].zf} || lat != int'(v[i].lat)) begin
                n_bad++;
                $display("FAIL incdec[%0d]: got c=%h cf=%b zf=%b lat=%0d, want c=%h cf=%b zf=%b lat=%0d",
                         i, rc, rcf, rzf, lat, v[i].c, v[i].cf, v[i].zf, v[i].lat);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v [6];
        logic [7:0] rc; logic rcf, rzf; int lat;
        v[0] = '{OP_SHL_A, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 8'd4};
        v[1] = '{OP_SHR_A, 8'h05, 8'h01, 8'h02, 1'b1, 1'b0, 8'd2};
        v[2] = '{OP_SHL_A, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 8'd1};
        v[3] = '{OP_SHR_A, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 8'd8};
        v[4] = '{OP_SHL_A, 8'h03, 8'h07, 8'h80, 1'b1, 1'b0, 8'd8};
        v[5] = '{OP_SHR_A, 8'hAF, 8'h0B, 8'h15, 1'b1, 1'b0, 8'd4};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, rc, rcf, rzf, lat);
            n_cmp++;
            if ({rc, rcf, rzf} !== {v[i].c, v[i].cf, v[i].zf} || lat != int'(v[i].lat)) begin
                n_bad++;
                $display("FAIL shift[%0d]: got c=%h cf=%b zf=%b lat=%0d, want c=%h cf=%b zf=%b lat=%0d",
                         i, rc, rcf, rzf, lat, v[i].c, v[i].cf, v[i].zf, v[i].lat);
            end
        end
    endtask

    task automatic test_mul();
        vec_t v [2];
        logic [7:0] rc; logic rcf, rzf; int lat;
`ifdef ALU_MUL_EN
        v[0] = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 8'd9};
        v[1] = '{OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 8'd9};
`else
        v[0] = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b0, 1'b0, 8'd1};
        v[1] = '{OP_MUL, 8'h00, 8'h0F, 8'h00, 1'b0, 1'b1, 8'd1};
`endif
        for (int i = 0; i < 2; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, rc, rcf, rzf, lat);
            n_cmp++;
            if ({rc, rcf, rzf} !== {v[i].c, v[i].cf, v[i].zf} || lat != int'(v[i].lat)) begin
                n_bad++;
                $display("FAIL mul[%0d]: got c=%h cf=%b zf=%b lat=%0d, want c=%h cf=%b zf=%b lat=%0d",
                         i, rc, rcf, rzf, lat, v[i].c, v[i].cf, v[i].zf, v[i].lat);
            end
        end
    endtask

    task automatic test_hold();
        bus.opcode = OP_ADD; bus.a = 8'h7F; bus.b = 8'h01; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // A competing request stays asserted while the result is stalled.
        bus.opcode = OP_SUB; bus.a = 8'h00; bus.b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({bus.out_valid, bus.c, bus.cf, bus.zf, bus.in_ready} !== {1'b1, 8'h80, 1'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold[%0d]: got ov=%b c=%h cf=%b zf=%b rdy=%b, want 1 80 0 0 0",
                         i, bus.out_valid, bus.c, bus.cf, bus.zf, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_release: got ov=%b busy=%b, want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_c;
        bus.out_ready = 1'b1;
        bus.opcode = OP_ADD; bus.a = 8'h00; bus.b = 8'h01; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_c = 8'((i * 16) + 1);
            n_cmp++;
            if ({bus.out_valid, bus.c, bus.in_ready} !== {1'b1, exp_c, 1'b1}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got ov=%b c=%h rdy=%b, want 1 %h 1",
                         i, bus.out_valid, bus.c, bus.in_ready, exp_c);
            end
            if (i < 3) bus.a = 8'((i + 1) * 16);
            else       bus.in_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_drain: got ov=%b busy=%b, want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int stale;
        bus.opcode = OP_SHR_A; bus.a = 8'hFF; bus.b = 8'h07; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, bus.out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL midop_busy: got busy=%b ov=%b, want 1 0", busy, bus.out_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.out_valid, bus.c, busy} !== {1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL midop_reset: got ov=%b c=%h busy=%b, want 0 00 0", bus.out_valid, bus.c, busy);
        end
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid || busy) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_bad++;
            $display("FAIL midop_stale: got %0d cycles with ov/busy set, want 0", stale);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode = OP_AND;
        bus.a = 8'h00;
        bus.b = 8'h00;
        test_reset();
        test_arith_logic();
        test_inc_dec();
        test_shift();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
